// File: rtl/bsg_rocket_pkg.sv
// Shared encodings and packed beat layouts for the NASTI memory server tunnel channel.
package bsg_rocket_pkg;

  localparam int unsigned bsg_nasti_id_width_gp   = 5;
  localparam int unsigned bsg_nasti_addr_width_gp = 32;

  typedef enum logic [1:0] {
    e_op_read  = 2'b00,
    e_op_write = 2'b01,
    e_op_ill2  = 2'b10,
    e_op_ill3  = 2'b11
  } bsg_nasti_op_e;

  typedef enum logic [1:0] {
    e_kind_rdata = 2'b00,
    e_kind_bresp = 2'b01
  } bsg_nasti_kind_e;

  typedef enum logic [1:0] {
    e_resp_okay   = 2'b00,
    e_resp_slverr = 2'b10
  } bsg_nasti_resp_e;

  // Fields are listed MSB-first; op / last / kind sit at bit 0 of the beat.
  typedef struct packed {
    logic [bsg_nasti_addr_width_gp-1:0] addr;
    logic [7:0]                         len;
    logic [bsg_nasti_id_width_gp-1:0]   id;
    bsg_nasti_op_e                      op;
  } bsg_nasti_mem_hdr_s;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } bsg_nasti_mem_wbeat_s;

  typedef struct packed {
    logic [63:0]                      data;
    logic [bsg_nasti_id_width_gp-1:0] id;
    logic                             last;
    bsg_nasti_resp_e                  resp;
    bsg_nasti_kind_e                  kind;
  } bsg_nasti_mem_rbeat_s;

  // True when a tunnel channel of the given width can carry every beat layout.
  function automatic bit bsg_nasti_mem_width_ok(input int unsigned width);
    return (width >= $bits(bsg_nasti_mem_hdr_s))
        && (width >= $bits(bsg_nasti_mem_wbeat_s))
        && (width >= $bits(bsg_nasti_mem_rbeat_s));
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write mask; contents are not reset.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int unsigned els_p        = 4096,
  parameter int unsigned data_width_p = 64,
  localparam int unsigned addr_width_lp = $clog2(els_p),
  localparam int unsigned mask_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]  data_o
);

  logic [data_width_p-1:0] mem_r [els_p];

  // Byte-masked write
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int unsigned i = 0; i < mask_width_lp; i++) begin
        if (write_mask_i[i]) mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end
    end
  end

  // Registered read data, valid the cycle after the read
  always_ff @(posedge clk_i) begin
    if (v_i && !w_i) data_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO; an enqueue into a full FIFO is accepted when a dequeue happens the same cycle.
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_r [2];
  logic               rd_ptr_r;
  logic               wr_ptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign v_o     = (count_r != 2'd0);
  assign deq     = yumi_i & v_o;
  assign ready_o = (count_r != 2'd2) | deq;
  assign enq     = v_i & ready_o;
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Pointers and occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_nasti_mem_server.sv
// Far-end SRAM target for serialized NASTI request packets; returns rdata / bresp beats.
module bsg_nasti_mem_server
  import bsg_rocket_pkg::*;
#(
  parameter int unsigned width_p      = 80,
  parameter int unsigned els_p        = 4096,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned id_width_p   = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_v_i,
  input  logic [width_p-1:0] req_data_i,
  output logic               req_yumi_o,
  output logic               resp_v_o,
  output logic [width_p-1:0] resp_data_o,
  input  logic               resp_yumi_i
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam int unsigned rbeat_lp  = $bits(bsg_nasti_mem_rbeat_s);

  if (!bsg_nasti_mem_width_ok(width_p)) begin : g_bad_width
    $error("bsg_nasti_mem_server: width_p too small for packed beats");
  end
  if ((id_width_p != bsg_nasti_id_width_gp) || (addr_width_p != bsg_nasti_addr_width_gp)) begin : g_bad_fields
    $error("bsg_nasti_mem_server: id/addr widths must match bsg_rocket_pkg");
  end
  if ((1 << lg_els_lp) != els_p) begin : g_bad_els
    $error("bsg_nasti_mem_server: els_p must be a power of 2");
  end

  typedef enum logic [1:0] {e_idle, e_rd, e_wr, e_bresp} state_e;

  state_e                           state_r;
  logic [bsg_nasti_id_width_gp-1:0] id_r;
  logic [7:0]                       len_r;
  logic [lg_els_lp-1:0]             base_r;
  logic                             err_r;
  logic [8:0]                       beat_r;
  logic                             rd_pending_r;
  logic                             rd_last_r;

  bsg_nasti_mem_hdr_s   hdr;
  bsg_nasti_mem_wbeat_s wbeat;
  bsg_nasti_mem_rbeat_s rd_beat;
  bsg_nasti_mem_rbeat_s push_beat;
  logic [lg_els_lp-1:0] hdr_base;
  logic                 hdr_err;

  logic                 req_yumi;
  logic                 rd_issue;
  logic                 wr_en;
  logic [lg_els_lp-1:0] sram_addr;
  logic [63:0]          sram_data;
  logic                 push_v;

  logic [1:0]           fifo_count;
  logic                 fifo_v;
  logic                 fifo_ready;
  logic [rbeat_lp-1:0]  fifo_data;
  logic                 deq;
  logic [2:0]           occ;
  logic                 room;

  logic [width_p:0]     unused_bits;

  assign hdr   = bsg_nasti_mem_hdr_s'(req_data_i[$bits(bsg_nasti_mem_hdr_s)-1:0]);
  assign wbeat = bsg_nasti_mem_wbeat_s'(req_data_i[$bits(bsg_nasti_mem_wbeat_s)-1:0]);
  assign unused_bits = {req_data_i, wbeat.last};

  assign hdr_base = hdr.addr[3 +: lg_els_lp];
  assign hdr_err  = ((32'(hdr_base) + 32'(hdr.len)) >= els_p)
                 || ((hdr.addr >> (3 + lg_els_lp)) != '0);

  // Beats already queued or in flight from the SRAM, net of this cycle's dequeue;
  // keeping it below 2 means a pending read always finds FIFO space.
  assign deq  = fifo_v & resp_yumi_i;
  assign occ  = 3'(fifo_count) + 3'(rd_pending_r) - 3'(deq);
  assign room = (occ < 3'd2);

  // Read-data beat formed from the SRAM output on the cycle after an issue
  always_comb begin
    rd_beat      = '0;
    rd_beat.kind = e_kind_rdata;
    rd_beat.resp = err_r ? e_resp_slverr : e_resp_okay;
    rd_beat.last = rd_last_r;
    rd_beat.id   = id_r;
    rd_beat.data = err_r ? '0 : sram_data;
  end

  // Handshakes, SRAM port control and FIFO push selection
  always_comb begin
    req_yumi  = 1'b0;
    rd_issue  = 1'b0;
    wr_en     = 1'b0;
    sram_addr = base_r + lg_els_lp'(beat_r);
    push_v    = 1'b0;
    push_beat = rd_beat;
    case (state_r)
      e_idle: begin
        if (req_v_i) begin
          req_yumi = 1'b1;
          // First read goes out with the header so data is queued one cycle later.
          if ((hdr.op == e_op_read) && room) begin
            rd_issue  = 1'b1;
            sram_addr = hdr_base;
          end
        end
      end
      e_rd: begin
        if ((beat_r <= 9'(len_r)) && room) rd_issue = 1'b1;
      end
      e_wr: begin
        if (req_v_i) begin
          req_yumi = 1'b1;
          wr_en    = !err_r && (wbeat.strb != '0);
        end
      end
      e_bresp: begin
        push_v         = 1'b1;
        push_beat.kind = e_kind_bresp;
        push_beat.resp = err_r ? e_resp_slverr : e_resp_okay;
        push_beat.last = 1'b1;
        push_beat.id   = id_r;
        push_beat.data = '0;
      end
      default: ;
    endcase
    if (rd_pending_r) begin
      push_v    = 1'b1;
      push_beat = rd_beat;
    end
  end

  assign req_yumi_o = req_yumi & ~reset_i;

  // Request FSM, burst counters and read pipeline tracking
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      id_r         <= '0;
      len_r        <= '0;
      base_r       <= '0;
      err_r        <= 1'b0;
      beat_r       <= '0;
      rd_pending_r <= 1'b0;
      rd_last_r    <= 1'b0;
    end else begin
      rd_pending_r <= rd_issue;
      if (rd_issue) rd_last_r <= (state_r == e_idle) ? (hdr.len == '0) : (beat_r == 9'(len_r));
      case (state_r)
        e_idle: begin
          if (req_v_i) begin
            id_r   <= hdr.id;
            len_r  <= hdr.len;
            base_r <= hdr_base;
            err_r  <= hdr_err;
            beat_r <= rd_issue ? 9'd1 : 9'd0;
            if (hdr.op == e_op_read)       state_r <= e_rd;
            else if (hdr.op == e_op_write) state_r <= e_wr;
          end
        end
        e_rd: begin
          if (rd_issue) beat_r <= beat_r + 9'd1;
          if (rd_pending_r && rd_last_r) state_r <= e_idle;
        end
        e_wr: begin
          if (req_v_i) begin
            beat_r <= beat_r + 9'd1;
            if (beat_r == 9'(len_r)) state_r <= e_bresp;
          end
        end
        e_bresp: begin
          if (fifo_ready) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (els_p),
    .data_width_p (64)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (rd_issue | wr_en),
    .w_i          (wr_en),
    .addr_i       (sram_addr),
    .data_i       (wbeat.data),
    .write_mask_i (wbeat.strb),
    .data_o       (sram_data)
  );

  bsg_two_fifo #(
    .width_p (rbeat_lp)
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready),
    .data_i  (push_beat),
    .v_i     (push_v),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (resp_yumi_i),
    .count_o (fifo_count)
  );

  assign resp_v_o    = fifo_v;
  assign resp_data_o = fifo_v ? width_p'(fifo_data) : '0;

endmodule

// File: tb/tb_bsg_nasti_mem_server.sv
// Directed self-checking bench for bsg_nasti_mem_server.
module tb_bsg_nasti_mem_server;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_v_i;
  logic [79:0] req_data_i;
  logic        req_yumi_o;
  logic        resp_v_o;
  logic [79:0] resp_data_o;
  logic        resp_yumi_i;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] got_data [16];
  logic [4:0]  got_id   [16];
  logic        got_last [16];
  logic [1:0]  got_resp [16];
  logic [1:0]  got_kind [16];
  int          got_cyc  [16];
  int          num_got;
  int          stall_err;

  always #5 clk = ~clk;

  bsg_nasti_mem_server #(
    .width_p      (80),
    .els_p        (4096),
    .addr_width_p (32),
    .id_width_p   (5)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_v_i     (req_v_i),
    .req_data_i  (req_data_i),
    .req_yumi_o  (req_yumi_o),
    .resp_v_o    (resp_v_o),
    .resp_data_o (resp_data_o),
    .resp_yumi_i (resp_yumi_i)
  );

  function automatic logic [79:0] mk_hdr(input logic [1:0] op, input logic [4:0] id,
                                         input logic [7:0] len, input logic [31:0] addr);
    return {33'b0, addr, len, id, op};
  endfunction

  function automatic logic [79:0] mk_wbeat(input logic [63:0] data, input logic [7:0] strb,
                                           input logic last);
    return {7'b0, data, strb, last};
  endfunction

  // Present a beat at a negedge, wait for yumi, return at the negedge after it is taken.
  task automatic drive_beat(input logic [79:0] d, output int waited);
    req_v_i = 1'b1;
    req_data_i = d;
    waited = 0;
    #1;
    while (!req_yumi_o && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Consume up to n response beats; cycle index 0 is the negedge at entry.
  task automatic collect(input int n, input int budget, input bit toggle);
    logic        prev_stall;
    logic [79:0] prev_data;
    num_got = 0; stall_err = 0; prev_stall = 1'b0; prev_data = '0;
    for (int k = 0; k < 16; k++) begin
      got_data[k] = 'x; got_id[k] = 'x; got_last[k] = 'x; got_resp[k] = 'x; got_kind[k] = 'x;
      got_cyc[k] = -1;
    end
    for (int it = 0; it < budget && num_got < n; it++) begin
      resp_yumi_i = toggle ? ((it % 2) == 0) : 1'b1;
      #1;
      if (prev_stall && (!resp_v_o || resp_data_o !== prev_data)) stall_err++;
      prev_stall = resp_v_o && !resp_yumi_i;
      prev_data = resp_data_o;
      if (resp_v_o && resp_yumi_i) begin
        got_kind[num_got] = resp_data_o[1:0];
        got_resp[num_got] = resp_data_o[3:2];
        got_last[num_got] = resp_data_o[4];
        got_id[num_got]   = resp_data_o[9:5];
        got_data[num_got] = resp_data_o[73:10];
        got_cyc[num_got]  = it;
        num_got++;
      end
      @(negedge clk);
    end
    resp_yumi_i = 1'b0;
  endtask

  // Header plus len+1 data beats of value base+i*step, then gather the bresp.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [4:0] id,
                          input logic [63:0] base, input logic [63:0] step,
                          input logic [7:0] strb, output int prompt_yumis);
    int w;
    prompt_yumis = 0;
    @(negedge clk);
    drive_beat(mk_hdr(2'b01, id, len, addr), w);
    for (int i = 0; i <= int'(len); i++) begin
      drive_beat(mk_wbeat(base + 64'(i) * step, strb, 1'(i == int'(len))), w);
      if (w == 0) prompt_yumis++;
    end
    req_v_i = 1'b0;
    collect(1, 12, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [4:0] id,
                         input bit toggle);
    int w;
    @(negedge clk);
    drive_beat(mk_hdr(2'b00, id, len, addr), w);
    req_v_i = 1'b0;
    collect(int'(len) + 1, 4 * (int'(len) + 1) + 12, toggle);
  endtask

  task automatic test_reset;
    reset_i = 1'b1; req_v_i = 1'b0; req_data_i = '0; resp_yumi_i = 1'b0;
    repeat (2) @(negedge clk);
    req_v_i = 1'b1;
    req_data_i = mk_hdr(2'b00, 5'd1, 8'd0, 32'h0);
    #1;
    tests_run++;
    if (req_yumi_o !== 1'b0 || resp_v_o !== 1'b0 || resp_data_o !== 80'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: yumi=%b v=%b data=%h, required 0/0/0", req_yumi_o, resp_v_o, resp_data_o);
    end
    @(negedge clk);
    req_v_i = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic test_write_read;
    int y;
    do_write(32'h100, 8'd3, 5'd5, 64'h11, 64'h11, 8'hFF, y);
    tests_run++;
    if (y !== 4) begin tests_failed++; $display("FAIL wr_yumis: got %0d required 4", y); end
    tests_run++;
    if (num_got !== 1 || got_kind[0] !== 2'b01 || got_resp[0] !== 2'b00 || got_last[0] !== 1'b1 ||
        got_id[0] !== 5'd5 || got_data[0] !== 64'h0) begin
      tests_failed++;
      $display("FAIL wr_bresp: n=%0d kind=%b resp=%b last=%b id=%0d data=%h, required 1/01/00/1/5/0",
               num_got, got_kind[0], got_resp[0], got_last[0], got_id[0], got_data[0]);
    end
    tests_run++;
    if (got_cyc[0] !== 1) begin tests_failed++; $display("FAIL bresp_latency: idx %0d required 1", got_cyc[0]); end

    do_read(32'h100, 8'd3, 5'd7, 1'b0);
    tests_run++;
    if (num_got !== 4) begin tests_failed++; $display("FAIL rd_count: got %0d required 4", num_got); end
    tests_run++;
    if (got_cyc[0] !== 1) begin tests_failed++; $display("FAIL rd_latency: idx %0d required 1", got_cyc[0]); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_data[i] !== 64'h11 * 64'(i + 1) || got_last[i] !== 1'(i == 3) || got_id[i] !== 5'd7 ||
          got_kind[i] !== 2'b00 || got_resp[i] !== 2'b00 || got_cyc[i] !== i + 1) begin
        tests_failed++;
        $display("FAIL rd_beat%0d: data=%h last=%b id=%0d kind=%b resp=%b idx=%0d, required %h/%b/7/00/00/%0d",
                 i, got_data[i], got_last[i], got_id[i], got_kind[i], got_resp[i], got_cyc[i],
                 64'h11 * 64'(i + 1), 1'(i == 3), i + 1);
      end
    end
  endtask

  task automatic test_strobe;
    int y;
    do_write(32'h200, 8'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF, y);
    do_write(32'h200, 8'd0, 5'd2, 64'h0, 64'h0, 8'h0F, y);
    do_read(32'h200, 8'd0, 5'd3, 1'b0);
    tests_run++;
    if (num_got !== 1 || got_data[0] !== 64'hFFFF_FFFF_0000_0000 || got_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL strobe: n=%0d data=%h last=%b, required 1/ffffffff00000000/1", num_got, got_data[0], got_last[0]);
    end
  endtask

  task automatic test_range_error;
    int y;
    do_write(32'h7FF0, 8'd1, 5'd2, 64'hC0DE_0000, 64'h1, 8'hFF, y);
    tests_run++;
    if (num_got !== 1 || got_resp[0] !== 2'b00) begin
      tests_failed++; $display("FAIL edge_wr_ok: n=%0d resp=%b required 1/00", num_got, got_resp[0]);
    end
    do_read(32'h7FF0, 8'd3, 5'd4, 1'b0);
    tests_run++;
    if (num_got !== 4) begin tests_failed++; $display("FAIL err_rd_count: got %0d required 4", num_got); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_data[i] !== 64'h0 || got_resp[i] !== 2'b10 || got_last[i] !== 1'(i == 3) || got_id[i] !== 5'd4) begin
        tests_failed++;
        $display("FAIL err_rd_beat%0d: data=%h resp=%b last=%b id=%0d, required 0/10/%b/4",
                 i, got_data[i], got_resp[i], got_last[i], got_id[i], 1'(i == 3));
      end
    end
    do_write(32'h7FF0, 8'd3, 5'd6, 64'hDEAD_0000, 64'h1, 8'hFF, y);
    tests_run++;
    if (num_got !== 1 || got_resp[0] !== 2'b10 || got_id[0] !== 5'd6 || got_kind[0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL err_bresp: n=%0d resp=%b id=%0d kind=%b, required 1/10/6/01", num_got, got_resp[0], got_id[0], got_kind[0]);
    end
    do_read(32'h7FF0, 8'd1, 5'd8, 1'b0);
    tests_run++;
    if (num_got !== 2 || got_data[0] !== 64'hC0DE_0000 || got_data[1] !== 64'hC0DE_0001 ||
        got_resp[0] !== 2'b00 || got_resp[1] !== 2'b00) begin
      tests_failed++;
      $display("FAIL err_wr_suppressed: n=%0d d0=%h d1=%h, required 2/c0de0000/c0de0001", num_got, got_data[0], got_data[1]);
    end
    do_read(32'h8000, 8'd0, 5'd9, 1'b0);
    tests_run++;
    if (num_got !== 1 || got_resp[0] !== 2'b10 || got_data[0] !== 64'h0) begin
      tests_failed++;
      $display("FAIL high_addr: n=%0d resp=%b data=%h, required 1/10/0", num_got, got_resp[0], got_data[0]);
    end
  endtask

  task automatic test_stall_read;
    int y;
    do_write(32'h300, 8'd7, 5'd1, 64'h5000, 64'h101, 8'hFF, y);
    do_read(32'h300, 8'd7, 5'd12, 1'b1);
    tests_run++;
    if (num_got !== 8) begin tests_failed++; $display("FAIL stall_count: got %0d required 8", num_got); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_data[i] !== 64'h5000 + 64'h101 * 64'(i) || got_last[i] !== 1'(i == 7)) begin
        tests_failed++;
        $display("FAIL stall_beat%0d: data=%h last=%b, required %h/%b", i, got_data[i], got_last[i],
                 64'h5000 + 64'h101 * 64'(i), 1'(i == 7));
      end
    end
    tests_run++;
    if (stall_err !== 0) begin tests_failed++; $display("FAIL stall_hold: %0d dropped/changed beats, required 0", stall_err); end
    collect(1, 5, 1'b0);
    tests_run++;
    if (num_got !== 0) begin tests_failed++; $display("FAIL stall_extra: %0d extra beats, required 0", num_got); end
  endtask

  task automatic test_illegal_op;
    int w;
    @(negedge clk);
    drive_beat(mk_hdr(2'b10, 5'd3, 8'd0, 32'h100), w);
    req_v_i = 1'b0;
    collect(1, 6, 1'b0);
    tests_run++;
    if (w !== 0 || num_got !== 0) begin
      tests_failed++; $display("FAIL illegal_op: wait=%0d beats=%0d, required 0/0", w, num_got);
    end
    do_read(32'h100, 8'd0, 5'd4, 1'b0);
    tests_run++;
    if (num_got !== 1 || got_data[0] !== 64'h11) begin
      tests_failed++; $display("FAIL after_illegal: n=%0d data=%h, required 1/11", num_got, got_data[0]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int y;
    int w;
    do_write(32'h400, 8'd3, 5'd1, 64'hA0, 64'h1, 8'hFF, y);
    @(negedge clk);
    drive_beat(mk_hdr(2'b01, 5'd3, 8'd7, 32'h400), w);
    for (int i = 0; i < 3; i++) drive_beat(mk_wbeat(64'hB0 + 64'(i), 8'hFF, 1'b0), w);
    req_data_i = mk_wbeat(64'hB3, 8'hFF, 1'b0);
    reset_i = 1'b1;
    #1;
    tests_run++;
    if (req_yumi_o !== 1'b0 || resp_v_o !== 1'b0 || resp_data_o !== 80'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: yumi=%b v=%b data=%h, required 0/0/0", req_yumi_o, resp_v_o, resp_data_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    req_v_i = 1'b0;
    do_read(32'h400, 8'd3, 5'd9, 1'b0);
    tests_run++;
    if (num_got !== 4 || got_cyc[0] !== 1 || got_data[0] !== 64'hB0 || got_data[1] !== 64'hB1 ||
        got_data[2] !== 64'hB2 || got_data[3] !== 64'hA3) begin
      tests_failed++;
      $display("FAIL post_reset_read: n=%0d idx0=%0d d=%h %h %h %h, required 4/1/b0 b1 b2 a3",
               num_got, got_cyc[0], got_data[0], got_data[1], got_data[2], got_data[3]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_range_error();
    test_stall_read();
    test_illegal_op();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
